// File: rtl/fp16_mul_arbiter_pkg.sv
// fp16_mul_pkg: shared fp16 constants and the multiplier tag type
package fp16_mul_pkg;
  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam int MUL_LAT_DEFAULT = 2;
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic vld;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;
endpackage

// File: rtl/fp16_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic w_found;
  // scan from the farthest offset down so the nearest request to ptr is the last writer
  always_comb begin
    w_found = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        w_found = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
    gnt = w_found ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one fixed-latency fp16 multiplier; optional MUL_ARB_STATS_EN counters
module fp16_mul_arbiter
  import fp16_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [FP16_W*N_REQ-1:0] req_a,
  input  logic [FP16_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        res_valid,
  output logic [FP16_W-1:0]       res_data,
  output logic                    busy,
  output logic [FP16_W-1:0]       mul_a,
  output logic [FP16_W-1:0]       mul_b,
  output logic                    mul_en,
`ifdef MUL_ARB_STATS_EN
  output logic [15:0]             stat_ops,
  output logic [15:0]             stat_conflicts,
`endif
  input  logic [FP16_W-1:0]       mul_out
);
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_acc;
  logic             w_any_vld;
  mul_tag_t         r_tag [0:MUL_LAT];
  rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .req(req_valid),
    .ptr(r_rr_ptr),
    .gnt(w_gnt),
    .gnt_idx(w_idx)
  );
  assign req_ready = (issue_en && !rst) ? w_gnt : '0;
  assign w_acc = |(req_ready & req_valid);
  // an op counts as outstanding until its res_valid cycle has ended
  always_comb begin
    w_any_vld = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) w_any_vld = w_any_vld | r_tag[k].vld;
    busy = w_any_vld | mul_en | (|res_valid);
  end
  // issue to the multiplier, shift the tag pipe, and capture mul_out when the head tag is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      mul_en <= 1'b0;
      mul_a <= FP16_ZERO;
      mul_b <= FP16_ZERO;
      res_valid <= '0;
      res_data <= FP16_ZERO;
      for (int k = 0; k <= MUL_LAT; k++) r_tag[k] <= '0;
    end else begin
      mul_en <= w_acc;
      if (w_acc) begin
        mul_a <= req_a[FP16_W*w_idx +: FP16_W];
        mul_b <= req_b[FP16_W*w_idx +: FP16_W];
        r_rr_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      r_tag[0] <= {w_acc, TAG_ID_W'(w_idx)};
      for (int k = 1; k <= MUL_LAT; k++) r_tag[k] <= r_tag[k-1];
      res_valid <= r_tag[MUL_LAT].vld ? (N_REQ'(1) << r_tag[MUL_LAT].id) : '0;
      if (r_tag[MUL_LAT].vld) res_data <= mul_out;
    end
  end
`ifdef MUL_ARB_STATS_EN
  logic w_conflict;
  assign w_conflict = issue_en && ((req_valid & (req_valid - 1'b1)) != '0);
  // accept count wraps, contention count saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_conflicts <= '0;
    end else begin
      if (w_acc) stat_ops <= stat_ops + 1'b1;
      if (w_conflict && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed stimulus with queued expectations checked by a result monitor
module tb_fp16_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_en = 1'b1;
  logic [3:0]  req_valid = 4'hF;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_ready, res_valid;
  logic [15:0] res_data, mul_a, mul_b, mul_out;
  logic        busy, mul_en;
`ifdef MUL_ARB_STATS_EN
  logic [15:0] stat_ops, stat_conflicts;
`endif
  fp16_mul_arbiter dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .res_valid(res_valid),
    .res_data(res_data), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
`ifdef MUL_ARB_STATS_EN
    .stat_ops(stat_ops), .stat_conflicts(stat_conflicts),
`endif
    .mul_out(mul_out)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4000;
      32'h3C00_3C00: return 16'h3C00;
      32'h4000_4000: return 16'h4400;
      32'h3E00_4000: return 16'h4200;
      32'h4200_4000: return 16'h4600;
      32'h3800_4000: return 16'h3C00;
      default:       return 16'hDEAD;
    endcase
  endfunction
  logic [15:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= mul_en ? fmul(mul_a, mul_b) : 16'hBAD0;
    p2 <= p1;
  end
  assign mul_out = p2;
  typedef struct {
    int id;
    logic [15:0] d;
    int due;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (res_valid != 4'h0) begin
      if (q.size() == 0) chk("unexpected_res_valid", {28'h0, res_valid}, 32'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("res_valid", {28'h0, res_valid}, 32'h1 << e.id);
        chk("res_data", {16'h0, res_data}, {16'h0, e.d});
        chk("res_latency", cyc, e.due);
      end
    end
  end
  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic setops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask
  task automatic step(input logic ie, input logic [3:0] v, input logic [3:0] rdy,
                      input logic [15:0] d, input bit push);
    issue_en = ie;
    req_valid = v;
    @(negedge clk);
    chk("req_ready", {28'h0, req_ready}, {28'h0, rdy});
    if (push && rdy != 4'h0) q.push_back('{id: oh2i(rdy), d: d, due: cyc + 4});
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int eb);
    req_valid = 4'h0;
    @(negedge clk);
    if (eb >= 0) chk("busy", {31'h0, busy}, eb);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      tick(-1);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    tick(0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    chk("rst_req_ready", {28'h0, req_ready}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_res_valid", {28'h0, res_valid}, 0);
    chk("rst_mul_en", {31'h0, mul_en}, 0);
    chk("rst_res_data", {16'h0, res_data}, 0);
    @(posedge clk);
    #1;
    do_reset();
    setops(0, 16'h3C00, 16'h4000);
    step(1, 4'b0001, 4'b0001, 16'h4000, 1);
    tick(1);
    tick(1);
    tick(1);
    tick(-1);
    tick(0);
    do_reset();
    setops(0, 16'h3C00, 16'h3C00);
    setops(1, 16'h4000, 16'h4000);
    setops(2, 16'h3E00, 16'h4000);
    setops(3, 16'h4200, 16'h4000);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ed [4];
      ed = '{16'h3C00, 16'h4400, 16'h4200, 16'h4600};
      step(1, 4'hF, 4'(1 << (k % 4)), ed[k % 4], 1);
    end
    drain();
    do_reset();
    setops(1, 16'h3800, 16'h4000);
    setops(3, 16'h4000, 16'h4000);
    for (int k = 0; k < 4; k++)
      step(1, 4'b1010, (k % 2 == 1) ? 4'b1000 : 4'b0010, (k % 2 == 1) ? 16'h4400 : 16'h3C00, 1);
    drain();
    do_reset();
    setops(0, 16'h3C00, 16'h4000);
    setops(1, 16'h4000, 16'h4000);
    step(1, 4'b0011, 4'b0001, 16'h4000, 1);
    step(1, 4'b0011, 4'b0010, 16'h4400, 1);
    for (int k = 0; k < 5; k++) step(0, 4'b0011, 4'b0000, 16'h0, 1);
    tick(0);
    step(1, 4'b0011, 4'b0001, 16'h4000, 1);
    drain();
    step(1, 4'b0001, 4'b0001, 16'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_res_data", {16'h0, res_data}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_mul_en", {31'h0, mul_en}, 0);
    chk("mid_rst_mul_a", {16'h0, mul_a}, 0);
    chk("mid_rst_mul_b", {16'h0, mul_b}, 0);
    chk("mid_rst_req_ready", {28'h0, req_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick(0);
    setops(0, 16'h3C00, 16'h3C00);
    setops(1, 16'h4000, 16'h4000);
    setops(2, 16'h3E00, 16'h4000);
    setops(3, 16'h4200, 16'h4000);
    step(1, 4'b0011, 4'b0001, 16'h3C00, 1);
    step(1, 4'b0011, 4'b0010, 16'h4400, 1);
    step(1, 4'b0110, 4'b0100, 16'h4200, 1);
    step(1, 4'b0001, 4'b0001, 16'h3C00, 1);
    step(1, 4'b1000, 4'b1000, 16'h4600, 1);
    step(0, 4'b1111, 4'b0000, 16'h0, 1);
    drain();
`ifdef MUL_ARB_STATS_EN
    chk("stat_ops", {16'h0, stat_ops}, 5);
    chk("stat_conflicts", {16'h0, stat_conflicts}, 3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
